br_fifo_pop_ctrl_staged: RTL and testbench



---
 rtl/br_fifo_pop_pkg.sv | 23 ++
 rtl/br_fifo_pop_staging.sv | 73 +++++++
 rtl/br_fifo_pop_ctrl_staged.sv | 157 +++++++++++++++
 tb/tb_br_fifo_pop_ctrl_staged.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/br_fifo_pop_pkg.sv
// Shared types and helpers for the FIFO pop-side controller.
//   staging_depth()   : staging entries needed to absorb every in-flight RAM read
//   clamped_clog2()   : address width that never collapses to zero bits
//   MaxRamReadLatency : largest supported RAM read latency
//   credit_t          : holds credit values up to StagingDepth+1
package br_fifo_pop_pkg;

  localparam int unsigned MaxRamReadLatency = 3;

  // Largest credit is StagingDepth+1 = MaxRamReadLatency+2.
  localparam int unsigned CreditWidth = $clog2(MaxRamReadLatency + 3);

  typedef logic [CreditWidth-1:0] credit_t;

  function automatic int unsigned staging_depth(input int unsigned ram_read_latency);
    return ram_read_latency + 1;
  endfunction

  function automatic int unsigned clamped_clog2(input int unsigned value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/br_fifo_pop_staging.sv
// Flop-based in-order staging FIFO. Entry 0 is always the head, so the output
// data comes straight from a flop; a pop shifts the remaining entries down.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   i_wr_valid   : write one entry this cycle
//   i_wr_data    : data to write
//   i_pop        : remove the head entry this cycle (only while o_valid)
//   o_valid      : at least one entry held
//   o_data       : head entry
//   o_occ        : number of entries held
module br_fifo_pop_staging #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 1,
  localparam int unsigned OccWidth = $clog2(Depth + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_wr_valid,
  input  logic [Width-1:0]    i_wr_data,
  input  logic                i_pop,
  output logic                o_valid,
  output logic [Width-1:0]    o_data,
  output logic [OccWidth-1:0] o_occ
);

  logic [Width-1:0]    r_mem [Depth];
  logic [Width-1:0]    w_above [Depth];
  logic [OccWidth-1:0] r_occ;
  logic [OccWidth-1:0] w_wr_idx;

  // Value each entry takes when the queue shifts down on a pop.
  for (genvar g = 0; g < Depth; g++) begin : g_above
    if (g + 1 < Depth) begin : g_shift
      assign w_above[g] = r_mem[g + 1];
    end else begin : g_tail
      assign w_above[g] = '0;
    end
  end

  // A same-cycle pop frees the slot below the current tail, so a full
  // queue can still accept a write while popping.
  assign w_wr_idx = r_occ - OccWidth'(i_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        r_mem[i] <= '0;
      end
      r_occ <= '0;
    end else begin
      for (int i = 0; i < Depth; i++) begin
        if (i_wr_valid && (w_wr_idx == OccWidth'(i))) begin
          r_mem[i] <= i_wr_data;
        end else if (i_pop) begin
          r_mem[i] <= w_above[i];
        end
      end
      r_occ <= r_occ + OccWidth'(i_wr_valid) - OccWidth'(i_pop);
    end
  end

  assign o_valid = (r_occ != '0);
  assign o_data  = r_mem[0];
  assign o_occ   = r_occ;

`ifndef SYNTHESIS
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(i_wr_valid && !i_pop && (r_occ == OccWidth'(Depth))));
  a_no_underflow : assert property (@(posedge clk) disable iff (rst)
    !(i_pop && (r_occ == '0)));
`endif

endmodule

// File: rtl/br_fifo_pop_ctrl_staged.sv
// Pop-side controller of the ready/valid FIFO. Issues RAM reads against a
// credit held by a small staging FIFO, optionally accepts the push side's
// bypass path while the RAM and read pipe are empty, and reports item counts.
// Build option: define BR_FIFO_POP_CTRL_BYPASS_EN to build the bypass path;
// otherwise bypass_ready is tied low and every push travels through RAM.
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   push_beat                    : push side accepted one item
//   bypass_ready                 : a push this cycle may go straight to staging
//   bypass_valid_unstable/_data  : bypass offer from the push side
//   ram_rd_addr_valid/ram_rd_addr: RAM read issue
//   ram_rd_data_valid/ram_rd_data: RAM read return
//   pop_ready/pop_valid/pop_data : consumer handshake
//   pop_beat                     : pop handshake, visible to the push side
//   empty/empty_next             : FIFO empty flag and its next value
//   items/items_next             : FIFO item count and its next value
module br_fifo_pop_ctrl_staged
  import br_fifo_pop_pkg::*;
#(
  parameter int unsigned Depth          = 2,
  parameter int unsigned Width          = 1,
  parameter int unsigned RamDepth       = Depth,
  parameter int unsigned RamReadLatency = 1,
  localparam int unsigned AddrWidth     = clamped_clog2(RamDepth),
  localparam int unsigned CountWidth    = $clog2(Depth + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_beat,
  output logic                  bypass_ready,
  input  logic                  bypass_valid_unstable,
  input  logic [Width-1:0]      bypass_data_unstable,
  output logic                  ram_rd_addr_valid,
  output logic [AddrWidth-1:0]  ram_rd_addr,
  input  logic                  ram_rd_data_valid,
  input  logic [Width-1:0]      ram_rd_data,
  input  logic                  pop_ready,
  output logic                  pop_valid,
  output logic [Width-1:0]      pop_data,
  output logic                  pop_beat,
  output logic                  empty,
  output logic                  empty_next,
  output logic [CountWidth-1:0] items,
  output logic [CountWidth-1:0] items_next
);

  localparam int unsigned StagingDepth  = staging_depth(RamReadLatency);
  localparam int unsigned OccWidth      = $clog2(StagingDepth + 1);
  localparam int unsigned RamCountWidth = $clog2(RamDepth + 1);

  logic [CountWidth-1:0]    r_items;
  logic                     r_empty;
  logic [RamCountWidth-1:0] r_ram_count;
  logic [OccWidth-1:0]      r_inflight;
  logic [AddrWidth-1:0]     r_rd_ptr;

  logic [OccWidth-1:0]      w_occ;
  logic                     w_pop_valid;
  logic                     w_pop_beat;
  credit_t                  w_credit;
  logic                     w_credit_ok;
  logic                     w_issue;
  logic                     w_bypass_ready;
  logic                     w_bypass_take;
  logic                     w_ram_push;
  logic                     w_stage_wr;
  logic [Width-1:0]         w_stage_data;
  logic [CountWidth-1:0]    w_items_next;
  logic                     w_empty_next;

  assign w_pop_beat = w_pop_valid && pop_ready;

  // Free staging slots not already promised to reads in flight; a pop this
  // cycle hands its slot back immediately.
  assign w_credit    = credit_t'(StagingDepth) - credit_t'(w_occ) - credit_t'(r_inflight)
                     + credit_t'(w_pop_beat);
  assign w_credit_ok = (w_credit != '0);
  assign w_issue     = (r_ram_count != '0) && w_credit_ok;

`ifdef BR_FIFO_POP_CTRL_BYPASS_EN
  // Bypass only while nothing older sits in RAM or the read pipe.
  assign w_bypass_ready = (r_ram_count == '0) && (r_inflight == '0) && w_credit_ok;
  assign w_bypass_take  = w_bypass_ready && bypass_valid_unstable && push_beat;
  assign w_stage_data   = ram_rd_data_valid ? ram_rd_data : bypass_data_unstable;
`else
  logic w_unused_bypass;
  assign w_unused_bypass = ^{bypass_valid_unstable, bypass_data_unstable};
  assign w_bypass_ready  = 1'b0;
  assign w_bypass_take   = 1'b0;
  assign w_stage_data    = ram_rd_data;
`endif

  assign w_ram_push   = push_beat && !w_bypass_take;
  assign w_stage_wr   = w_bypass_take || ram_rd_data_valid;
  assign w_items_next = r_items + CountWidth'(push_beat) - CountWidth'(w_pop_beat);
  assign w_empty_next = (w_items_next == '0);

  // Item count and empty flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_items <= '0;
      r_empty <= 1'b1;
    end else begin
      r_items <= w_items_next;
      if (push_beat || w_pop_beat) begin
        r_empty <= w_empty_next;
      end
    end
  end

  // Unread RAM entries, reads in flight and the read pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ram_count <= '0;
      r_inflight  <= '0;
      r_rd_ptr    <= '0;
    end else begin
      r_ram_count <= r_ram_count + RamCountWidth'(w_ram_push) - RamCountWidth'(w_issue);
      r_inflight  <= r_inflight + OccWidth'(w_issue) - OccWidth'(ram_rd_data_valid);
      if (w_issue) begin
        r_rd_ptr <= (r_rd_ptr == AddrWidth'(RamDepth - 1)) ? '0 : r_rd_ptr + AddrWidth'(1);
      end
    end
  end

  br_fifo_pop_staging #(
    .Depth (StagingDepth),
    .Width (Width)
  ) u_staging (
    .clk        (clk),
    .rst        (rst),
    .i_wr_valid (w_stage_wr),
    .i_wr_data  (w_stage_data),
    .i_pop      (w_pop_beat),
    .o_valid    (w_pop_valid),
    .o_data     (pop_data),
    .o_occ      (w_occ)
  );

  assign bypass_ready      = w_bypass_ready;
  assign ram_rd_addr_valid = w_issue;
  assign ram_rd_addr       = r_rd_ptr;
  assign pop_valid         = w_pop_valid;
  assign pop_beat          = w_pop_beat;
  assign empty             = r_empty;
  assign empty_next        = w_empty_next;
  assign items             = r_items;
  assign items_next        = w_items_next;

`ifndef SYNTHESIS
`ifdef BR_FIFO_POP_CTRL_BYPASS_EN
  a_bypass_vs_return : assert property (@(posedge clk) disable iff (rst)
    !(w_bypass_take && ram_rd_data_valid));
`endif
`endif

endmodule

// File: tb/tb_br_fifo_pop_ctrl_staged.sv
// Bench for br_fifo_pop_ctrl_staged: plays the push controller and a
// fixed-latency RAM, and checks pops against an in-order queue model.
module tb_br_fifo_pop_ctrl_staged;

  localparam int unsigned Depth      = 4;
  localparam int unsigned Width      = 8;
  localparam int unsigned RamDepth   = 4;
  localparam int unsigned Lat        = 1;
  localparam int unsigned SD         = Lat + 1;
  localparam int unsigned AddrWidth  = 2;
  localparam int unsigned CountWidth = 3;
`ifdef BR_FIFO_POP_CTRL_BYPASS_EN
  localparam bit BypassEn = 1'b1;
`else
  localparam bit BypassEn = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  push_beat;
  logic                  bypass_ready;
  logic                  bypass_valid_unstable;
  logic [Width-1:0]      bypass_data_unstable;
  logic                  ram_rd_addr_valid;
  logic [AddrWidth-1:0]  ram_rd_addr;
  logic                  ram_rd_data_valid;
  logic [Width-1:0]      ram_rd_data;
  logic                  pop_ready;
  logic                  pop_valid;
  logic [Width-1:0]      pop_data;
  logic                  pop_beat;
  logic                  empty;
  logic                  empty_next;
  logic [CountWidth-1:0] items;
  logic [CountWidth-1:0] items_next;

  always #5 clk = ~clk;

  br_fifo_pop_ctrl_staged #(
    .Depth          (Depth),
    .Width          (Width),
    .RamDepth       (RamDepth),
    .RamReadLatency (Lat)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .push_beat             (push_beat),
    .bypass_ready          (bypass_ready),
    .bypass_valid_unstable (bypass_valid_unstable),
    .bypass_data_unstable  (bypass_data_unstable),
    .ram_rd_addr_valid     (ram_rd_addr_valid),
    .ram_rd_addr           (ram_rd_addr),
    .ram_rd_data_valid     (ram_rd_data_valid),
    .ram_rd_data           (ram_rd_data),
    .pop_ready             (pop_ready),
    .pop_valid             (pop_valid),
    .pop_data              (pop_data),
    .pop_beat              (pop_beat),
    .empty                 (empty),
    .empty_next            (empty_next),
    .items                 (items),
    .items_next            (items_next)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Push-side RAM: pushes that do not take the bypass are written here.
  logic [Width-1:0]     ram [RamDepth];
  logic [AddrWidth-1:0] wr_ptr;
  logic                 byp_take;

  assign byp_take = bypass_ready && bypass_valid_unstable && push_beat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_ptr <= '0;
    else if (push_beat && !byp_take)
      wr_ptr <= (wr_ptr == AddrWidth'(RamDepth - 1)) ? '0 : wr_ptr + AddrWidth'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst && push_beat && !byp_take) ram[wr_ptr] <= bypass_data_unstable;
  end

  // Fixed-latency read pipe.
  if (Lat == 0) begin : g_l0
    assign ram_rd_data_valid = ram_rd_addr_valid;
    assign ram_rd_data       = ram[ram_rd_addr];
  end else begin : g_lp
    logic             pv [Lat];
    logic [Width-1:0] pd [Lat];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < Lat; i++) begin
          pv[i] <= 1'b0;
          pd[i] <= '0;
        end
      end else begin
        pv[0] <= ram_rd_addr_valid;
        pd[0] <= ram[ram_rd_addr];
        for (int i = 1; i < Lat; i++) begin
          pv[i] <= pv[i-1];
          pd[i] <= pd[i-1];
        end
      end
    end
    assign ram_rd_data_valid = pv[Lat-1];
    assign ram_rd_data       = pd[Lat-1];
  end

  // Reference model: pushed items in order, plus visible traffic counters.
  logic [Width-1:0] q [$];
  int unsigned issues  = 0;   // RAM reads issued since reset
  int unsigned byps    = 0;   // bypasses taken since reset
  int unsigned rampend = 0;   // items written to RAM, not yet returned
  int unsigned staged  = 0;   // items delivered to staging, not yet popped
  int          cyc     = 0;
  logic        exp_pop;
  int          exp_next;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      exp_pop  = pop_valid && pop_ready;
      exp_next = q.size() + int'(push_beat) - int'(exp_pop);
      chk_val("pop_beat", pop_beat, exp_pop);
      chk_val("pop_valid", pop_valid, staged != 0);
      chk_val("items", items, q.size());
      chk_val("empty", empty, q.size() == 0);
      chk_val("items_next", items_next, exp_next);
      chk_val("empty_next", empty_next, exp_next == 0);
      if (exp_pop) begin
        chk_val("pop_nonempty", q.size() != 0, 1);
        if (q.size() != 0) begin
          chk_val("pop_data", pop_data, q[0]);
          void'(q.pop_front());
        end
      end
`ifdef BR_FIFO_POP_CTRL_BYPASS_EN
      if (byp_take) chk_val("byp_order", rampend, 0);
`else
      chk_val("byp_ready_off", bypass_ready, 0);
`endif
      if (ram_rd_addr_valid) begin
        chk_val("rd_addr", ram_rd_addr, issues % RamDepth);
        issues++;
      end
      staged = staged + int'(byp_take) + int'(ram_rd_data_valid) - int'(exp_pop);
      chk_val("stg_ovf", staged <= SD, 1);
      if (push_beat && !byp_take) rampend++;
      if (ram_rd_data_valid) rampend--;
      if (byp_take) byps++;
      if (push_beat) q.push_back(bypass_data_unstable);
    end
  end

  task automatic drive(input logic push, input logic [Width-1:0] d, input logic pr);
    @(posedge clk);
    #1;
    push_beat             = push;
    bypass_valid_unstable = push;
    bypass_data_unstable  = d;
    pop_ready             = pr;
  endtask

  task automatic do_reset();
    rst                   = 1'b1;
    push_beat             = 1'b0;
    bypass_valid_unstable = 1'b0;
    bypass_data_unstable  = '0;
    pop_ready             = 1'b0;
    #2;
    chk_val("rst_pop_valid", pop_valid, 0);
    chk_val("rst_empty", empty, 1);
    chk_val("rst_items", items, 0);
    chk_val("rst_rd_valid", ram_rd_addr_valid, 0);
    chk_val("rst_rd_addr", ram_rd_addr, 0);
    chk_val("rst_byp_ready", bypass_ready, BypassEn);
    q.delete();
    issues = 0; byps = 0; rampend = 0; staged = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic push_one_measure(input logic [Width-1:0] d, output logic byp, output int lat);
    drive(1'b1, d, 1'b0);
    @(negedge clk);
    byp = bypass_ready;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      drive(1'b0, '0, 1'b0);
      @(negedge clk);
      if (lat < 0 && pop_valid) lat = k;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || pop_valid) && n < 60) begin
      drive(1'b0, '0, 1'b1);
      @(negedge clk);
      n++;
    end
    chk_val("drain_empty", q.size(), 0);
    drive(1'b0, '0, 1'b0);
  endtask

  initial begin
    logic b;
    int   lat, iss0, byp0, first, last, npop, sent;

    do_reset();

    // Single push into an empty FIFO.
    push_one_measure(8'h0A, b, lat);
    chk_val("lat_empty", lat, BypassEn ? 1 : 2 + Lat);
    chk_val("lat_data", pop_data, 8'h0A);
    chk_val("lat_issues", issues, BypassEn ? 0 : 1);
    drain();

    // Burst of Depth pushes into a stalled consumer.
    iss0 = issues;
    byp0 = byps;
    for (int i = 0; i < Depth; i++) drive(1'b1, 8'(8'h10 + i), 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b0, '0, 1'b0);
    @(negedge clk);
    chk_val("burst_items", items, Depth);
    chk_val("burst_valid", pop_valid, 1);
    chk_val("burst_issues", issues - iss0, SD - (byps - byp0));
`ifdef BR_FIFO_POP_CTRL_BYPASS_EN
    chk_val("burst_byps", byps - byp0, SD);
`endif
    drain();

    // Full-rate stream: one pop every cycle after the first.
    first = -1; last = -1; npop = 0; sent = 0;
    for (int c = 0; c < 60 && npop < 16; c++) begin
      if (sent < 16 && q.size() < Depth) begin
        drive(1'b1, 8'(8'h40 + sent), 1'b1);
        sent++;
      end else begin
        drive(1'b0, '0, 1'b1);
      end
      @(negedge clk);
      if (pop_valid && pop_ready) begin
        if (first < 0) first = c;
        last = c;
        npop++;
      end
    end
    chk_val("stream_pops", npop, 16);
    chk_val("stream_span", last - first, 15);
    drain();

    // Push and pop together while holding two items.
    drive(1'b1, 8'h21, 1'b0);
    drive(1'b1, 8'h22, 1'b0);
    for (int i = 0; i < 8 && !pop_valid; i++) drive(1'b0, '0, 1'b0);
    @(negedge clk);
    chk_val("sim_pre_items", items, 2);
    drive(1'b1, 8'h23, 1'b1);
    @(negedge clk);
    chk_val("sim_pop_beat", pop_beat, 1);
    drive(1'b0, '0, 1'b0);
    @(negedge clk);
    chk_val("sim_items", items, 2);
    chk_val("sim_empty", empty, 0);
    drain();

    // Reset in the middle of a burst.
    for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'h30 + i), 1'b0);
    drive(1'b0, '0, 1'b0);
    @(posedge clk);
    #1;
    do_reset();
    push_one_measure(8'h5C, b, lat);
    chk_val("post_rst_byp", b, BypassEn);
    chk_val("post_rst_lat", lat, BypassEn ? 1 : 2 + Lat);
    chk_val("post_rst_data", pop_data, 8'h5C);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(9) < 6) && (q.size() < Depth), 8'($urandom), $urandom_range(9) < 7);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench did not complete");
  end

endmodule
